// File: rtl/slave_cmd_processor.sv
// -----------------------------------------------------------------------------
// slave_cmd_processor
//
// Purpose:
//   Receives a command frame from the I2C slave byte receiver and executes it.
//   A frame is one opcode byte followed by two big-endian operands A and B of
//   OPERAND_BYTES bytes each. The result of the ALU/multiply operation and a
//   4-character ASCII tag for the opcode are then offered to the display
//   driver on a valid/ready port.
//
// Parameters:
//   OPERAND_BYTES  bytes per operand (1..8); operand width W = 8*OPERAND_BYTES
//   TIMEOUT_CYCLES clk cycles without a byte mid-frame before the frame is
//                  dropped (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx_done    in   byte-complete flag, asynchronous; each rising edge = 1 byte
//   rx_data    in   received byte, stable from rx_done rise to the next rise
//   out_valid  out  result available
//   out_ready  in   display driver accepts the result
//   out_result out  2W-bit result
//   out_ascii  out  opcode tag, first character in [31:24]
//   out_err    out  opcode was illegal (qualified by out_valid)
//   ovf        out  sticky: a byte arrived while executing/holding and was lost
//   timeout    out  sticky: a frame was abandoned by inter-byte timeout
//   frame_cnt  out  number of accepted results, wraps
// -----------------------------------------------------------------------------
module slave_cmd_processor #(
    parameter int OPERAND_BYTES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_done,
    input  logic [7:0]                    rx_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [16*OPERAND_BYTES-1:0]   out_result,
    output logic [31:0]                   out_ascii,
    output logic                          out_err,
    output logic                          ovf,
    output logic                          timeout,
    output logic [7:0]                    frame_cnt
);

    localparam int W  = 8 * OPERAND_BYTES;
    localparam int RW = 2 * W;
    localparam int CW = 4;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [31:0] TAG_ADD  = 32'h4144_4420; // "ADD "
    localparam logic [31:0] TAG_SUB  = 32'h5355_4220; // "SUB "
    localparam logic [31:0] TAG_MULT = 32'h4D55_4C54; // "MULT"
    localparam logic [31:0] TAG_AND  = 32'h414E_4420; // "AND "
    localparam logic [31:0] TAG_OR   = 32'h4F52_2020; // "OR  "
    localparam logic [31:0] TAG_XOR  = 32'h584F_5220; // "XOR "
    localparam logic [31:0] TAG_ERR  = 32'h4552_5220; // "ERR "

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OPA  = 3'd1,
        ST_OPB  = 3'd2,
        ST_EXEC = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    // Receive strobe synchroniser
    logic rx_meta_r;
    logic rx_sync_r;
    logic rx_prev_r;
    logic byte_stb_s;

    // FSM
    state_t state_r;
    state_t state_nxt_s;
    logic   cap_op_s;
    logic   shift_a_s;
    logic   shift_b_s;
    logic   exec_s;
    logic   hs_s;
    logic   drop_s;
    logic   abandon_s;

    // Frame assembly
    logic [CW-1:0] byte_cnt_r;
    logic          last_byte_s;
    logic [TW-1:0] tmo_cnt_r;
    logic          tmo_exp_s;
    logic [2:0]    opc_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;

    // Execution
    logic [RW-1:0] a_ext_s;
    logic [RW-1:0] b_ext_s;
    logic [RW-1:0] res_s;
    logic [31:0]   tag_s;
    logic          err_s;

    // Output registers
    logic          out_valid_r;
    logic [RW-1:0] out_result_r;
    logic [31:0]   out_ascii_r;
    logic          out_err_r;
    logic          ovf_r;
    logic          timeout_r;
    logic [7:0]    frame_cnt_r;

    // Two-flop synchroniser for rx_done plus a delayed copy for edge detection.
    // Resetting to 0 makes rx_done already high at reset release count as a byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b0;
            rx_sync_r <= 1'b0;
            rx_prev_r <= 1'b0;
        end else begin
            rx_meta_r <= rx_done;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign byte_stb_s  = rx_sync_r & ~rx_prev_r;
    assign last_byte_s = (byte_cnt_r == CW'(OPERAND_BYTES - 1));
    assign tmo_exp_s   = (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and control decode; a byte strobe has priority over
    // timeout expiry in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        cap_op_s    = 1'b0;
        shift_a_s   = 1'b0;
        shift_b_s   = 1'b0;
        exec_s      = 1'b0;
        hs_s        = 1'b0;
        drop_s      = 1'b0;
        abandon_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (byte_stb_s) begin
                    cap_op_s    = 1'b1;
                    state_nxt_s = ST_OPA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OPA: begin
                if (byte_stb_s) begin
                    shift_a_s   = 1'b1;
                    state_nxt_s = last_byte_s ? ST_OPB : ST_OPA;
                end else if (tmo_exp_s) begin
                    abandon_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OPA;
                end
            end
            ST_OPB: begin
                if (byte_stb_s) begin
                    shift_b_s   = 1'b1;
                    state_nxt_s = last_byte_s ? ST_EXEC : ST_OPB;
                end else if (tmo_exp_s) begin
                    abandon_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OPB;
                end
            end
            ST_EXEC: begin
                exec_s      = 1'b1;
                drop_s      = byte_stb_s;
                state_nxt_s = ST_HOLD;
            end
            ST_HOLD: begin
                drop_s = byte_stb_s;
                if (out_valid_r && out_ready) begin
                    hs_s        = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Byte position within the current operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r <= {CW{1'b0}};
        end else if (cap_op_s || abandon_s) begin
            byte_cnt_r <= {CW{1'b0}};
        end else if (shift_a_s || shift_b_s) begin
            byte_cnt_r <= last_byte_s ? {CW{1'b0}} : byte_cnt_r + CW'(1);
        end else begin
            byte_cnt_r <= byte_cnt_r;
        end
    end

    // Inter-byte timeout counter; only runs while an operand is being received
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (byte_stb_s || abandon_s) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (state_r == ST_OPA || state_r == ST_OPB) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= {TW{1'b0}};
        end
    end

    // Opcode and operand capture; operands shift in MSB byte first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_r <= 3'd0;
            a_r   <= {W{1'b0}};
            b_r   <= {W{1'b0}};
        end else if (cap_op_s) begin
            opc_r <= rx_data[2:0];
            a_r   <= {W{1'b0}};
            b_r   <= {W{1'b0}};
        end else if (abandon_s) begin
            opc_r <= 3'd0;
            a_r   <= {W{1'b0}};
            b_r   <= {W{1'b0}};
        end else if (shift_a_s) begin
            a_r   <= W'({a_r, rx_data});
        end else if (shift_b_s) begin
            b_r   <= W'({b_r, rx_data});
        end else begin
            opc_r <= opc_r;
            a_r   <= a_r;
            b_r   <= b_r;
        end
    end

    assign a_ext_s = RW'(a_r);
    assign b_ext_s = RW'(b_r);

    // Operation decode; the 2W-bit product of two W-bit operands never truncates
    always_comb begin
        res_s = {RW{1'b0}};
        tag_s = TAG_ERR;
        err_s = 1'b1;
        case (opc_r)
            3'b000: begin res_s = a_ext_s + b_ext_s; tag_s = TAG_ADD;  err_s = 1'b0; end
            3'b001: begin res_s = a_ext_s - b_ext_s; tag_s = TAG_SUB;  err_s = 1'b0; end
            3'b010: begin res_s = a_ext_s * b_ext_s; tag_s = TAG_MULT; err_s = 1'b0; end
            3'b011: begin res_s = a_ext_s & b_ext_s; tag_s = TAG_AND;  err_s = 1'b0; end
            3'b100: begin res_s = a_ext_s | b_ext_s; tag_s = TAG_OR;   err_s = 1'b0; end
            3'b101: begin res_s = a_ext_s ^ b_ext_s; tag_s = TAG_XOR;  err_s = 1'b0; end
            default: begin
                res_s = {RW{1'b0}};
                tag_s = TAG_ERR;
                err_s = 1'b1;
            end
        endcase
    end

    // Result port: loaded in EXEC, held until the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {RW{1'b0}};
            out_ascii_r  <= 32'd0;
            out_err_r    <= 1'b0;
        end else if (exec_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= res_s;
            out_ascii_r  <= tag_s;
            out_err_r    <= err_s;
        end else if (hs_s) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    // Status: sticky flags and accepted-result counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r       <= 1'b0;
            timeout_r   <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            ovf_r       <= ovf_r | drop_s;
            timeout_r   <= timeout_r | abandon_s;
            frame_cnt_r <= hs_s ? frame_cnt_r + 8'd1 : frame_cnt_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_ascii  = out_ascii_r;
    assign out_err    = out_err_r;
    assign ovf        = ovf_r;
    assign timeout    = timeout_r;
    assign frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_slave_cmd_processor.sv
// -----------------------------------------------------------------------------
// tb_slave_cmd_processor
//
// Drives command frames through slave_cmd_processor (4-byte operands, short
// 16-cycle timeout) and compares every result against an arithmetic reference
// model of the opcode table.
// -----------------------------------------------------------------------------
module tb_slave_cmd_processor;

    localparam int OB = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] out_result;
    logic [31:0] out_ascii;
    logic        out_err;
    logic        ovf;
    logic        timeout;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int valid_cycles = 0;
    int hs_cyc = 0;
    int last_rise_cyc = 0;
    int exp_frames = 0;
    logic [63:0] cap_res;
    logic [31:0] cap_ascii;
    logic        cap_err;

    slave_cmd_processor #(.OPERAND_BYTES(OB), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ascii  (out_ascii),
        .out_err    (out_err),
        .ovf        (ovf),
        .timeout    (timeout),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor, sampled a little after the falling edge
    always @(negedge clk) begin
        #2;
        if (out_valid === 1'b1) begin
            valid_cycles++;
            if (out_ready === 1'b1) begin
                hs_cnt++;
                hs_cyc    = cyc;
                cap_res   = out_result;
                cap_ascii = out_ascii;
                cap_err   = out_err;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_res(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x;
        logic [63:0] y;
        x = {32'd0, a};
        y = {32'd0, b};
        case (int'(op) % 8)
            0: return x + y;
            1: return x - y;
            2: return x * y;
            3: return x & y;
            4: return x | y;
            5: return x ^ y;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_tag(input logic [7:0] op);
        case (int'(op) % 8)
            0: return "ADD ";
            1: return "SUB ";
            2: return "MULT";
            3: return "AND ";
            4: return "OR  ";
            5: return "XOR ";
            default: return "ERR ";
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data       = b;
        rx_done       = 1'b1;
        last_rise_cyc = cyc;
        repeat (3) @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        send_byte(op);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(b[8*i +: 8]);
    endtask

    // Full frame with out_ready high: one single-cycle result, fixed latency
    task automatic run_frame(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int hs0;
        int v0;
        hs0 = hs_cnt;
        v0  = valid_cycles;
        send_frame(op, a, b);
        for (int i = 0; i < 40 && hs_cnt == hs0; i++) @(negedge clk);
        @(negedge clk);
        exp_frames = (exp_frames + 1) % 256;
        check({tag, "_hs"},    64'(hs_cnt - hs0), 64'd1);
        check({tag, "_vcyc"},  64'(valid_cycles - v0), 64'd1);
        check({tag, "_lat"},   64'(hs_cyc - last_rise_cyc), 64'd4);
        check({tag, "_res"},   cap_res, ref_res(op, a, b));
        check({tag, "_ascii"}, 64'(cap_ascii), 64'(ref_tag(op)));
        check({tag, "_err"},   64'(cap_err), 64'((int'(op) % 8) >= 6));
        check({tag, "_fcnt"},  64'(frame_cnt), 64'(exp_frames));
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] held;
        int          hs0;

        rst_n     = 1'b0;
        rx_done   = 1'b0;
        rx_data   = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid",   64'(out_valid), 64'd0);
        check("rst_result",  out_result, 64'd0);
        check("rst_ascii",   64'(out_ascii), 64'd0);
        check("rst_err",     64'(out_err), 64'd0);
        check("rst_ovf",     64'(ovf), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_fcnt",    64'(frame_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed opcode cases with literal expectations
        run_frame("add", 8'h00, 32'h0000_0005, 32'h0000_0003);
        check("add_lit", cap_res, 64'h8);
        check("add_tag", 64'(cap_ascii), 64'h4144_4420);
        run_frame("mult", 8'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mult_lit", cap_res, 64'hFFFF_FFFE_0000_0001);
        run_frame("sub", 8'h01, 32'h0000_0001, 32'h0000_0002);
        check("sub_lit", cap_res, 64'hFFFF_FFFF_FFFF_FFFF);
        run_frame("err", 8'h07, 32'h1234_5678, 32'h9ABC_DEF0);
        check("err_lit", cap_res, 64'd0);
        check("err_tag", 64'(cap_ascii), 64'h4552_5220);
        check("err_flag", 64'(cap_err), 64'd1);
        run_frame("hibits", 8'hFD, 32'h0F0F_0F0F, 32'hFF00_FF00);

        // Random frames
        for (int n = 0; n < 24; n++) begin
            op = 8'($urandom_range(0, 255));
            a  = $urandom;
            b  = $urandom;
            if (n % 6 == 1) a = 32'hFFFF_FFFF;
            if (n % 6 == 2) b = 32'd0;
            run_frame($sformatf("rnd%0d", n), op, a, b);
        end
        check("pre_ovf",     64'(ovf), 64'd0);
        check("pre_timeout", 64'(timeout), 64'd0);

        // Back-pressure: result held while extra bytes are dropped
        out_ready = 1'b0;
        hs0 = hs_cnt;
        op  = 8'h04;
        a   = $urandom;
        b   = $urandom;
        send_frame(op, a, b);
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
        check("hold_valid", 64'(out_valid), 64'd1);
        held = out_result;
        check("hold_res0", held, ref_res(op, a, b));
        fork
            begin
                send_byte(8'hAA);
                send_byte(8'h55);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    check("hold_stable", out_result, held);
                    check("hold_vstay", 64'(out_valid), 64'd1);
                    check("hold_tag", 64'(out_ascii), 64'(ref_tag(op)));
                end
            end
        join
        check("hold_ovf",  64'(ovf), 64'd1);
        check("hold_nohs", 64'(hs_cnt - hs0), 64'd0);
        check("hold_fcnt", 64'(frame_cnt), 64'(exp_frames));
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        exp_frames = (exp_frames + 1) % 256;
        check("rel_hs",    64'(hs_cnt - hs0), 64'd1);
        check("rel_valid", 64'(out_valid), 64'd0);
        check("rel_fcnt",  64'(frame_cnt), 64'(exp_frames));
        run_frame("after_hold", 8'h05, $urandom, $urandom);
        check("ovf_sticky", 64'(ovf), 64'd1);

        // Timeout: partial frame then silence
        hs0 = hs_cnt;
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (20) @(negedge clk);
        check("tmo_flag",  64'(timeout), 64'd1);
        check("tmo_nohs",  64'(hs_cnt - hs0), 64'd0);
        check("tmo_valid", 64'(out_valid), 64'd0);
        run_frame("after_tmo", 8'h03, 32'h0F0F_0F0F, 32'h00FF_00FF);
        check("and_lit", cap_res, 64'h0000_0000_000F_000F);

        // Reset in the middle of operand B
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        send_byte(8'h20);
        send_byte(8'h21);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_fcnt",  64'(frame_cnt), 64'd0);
        check("mrst_ovf",   64'(ovf), 64'd0);
        check("mrst_tmo",   64'(timeout), 64'd0);
        rst_n = 1'b1;
        exp_frames = 0;
        hs0 = hs_cnt;
        repeat (2) @(negedge clk);
        run_frame("post_rst", 8'h00, 32'h1234_5678, 32'h1111_1111);
        check("post_rst_lit", cap_res, 64'h2345_6789);
        repeat (10) @(negedge clk);
        check("post_rst_once", 64'(hs_cnt - hs0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
